// File: rtl/dmem_bus_master.sv
// dmem_bus_master: initiator side of the data-memory bus.
// Accepts one load/store at a time from the pipeline, runs it on the
// MREQ/WRITE/SIZE/DAD/DDT/ACKD_n bus, and returns extended load data.
// Misaligned requests and acknowledge timeouts complete with resp_err.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_write/size/unsigned  access kind: store, 00 word/01 half/1x byte, zero-extend
//   req_addr, req_wdata      byte address, right-justified store data
//   resp_valid               one-cycle completion pulse
//   resp_rdata, resp_err     extended load data (0 for stores/errors), error flag
//   MREQ, WRITE, SIZE, DAD   bus request, direction, size, address
//   DDT                      bidirectional bus data, driven only while MREQ && WRITE
//   ACKD_n                   active-low acknowledge
//
// state | meaning
// IDLE  | waiting for a request; req_ready high
// BUS   | bus cycle in progress, waiting for ACKD_n or timeout
// DONE  | resp_valid pulse, then back to IDLE
module dmem_bus_master #(
  parameter int BIT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [BIT_WIDTH-1:0] req_addr,
  input  logic [BIT_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [BIT_WIDTH-1:0] resp_rdata,
  output logic                 resp_err,
  output logic                 MREQ,
  output logic                 WRITE,
  output logic [1:0]           SIZE,
  output logic [BIT_WIDTH-1:0] DAD,
  inout  wire  [BIT_WIDTH-1:0] DDT,
  input  logic                 ACKD_n
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  localparam bit             HAS_TIMEOUT = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                 state_q, state_d;
  logic                   mreq_q, mreq_d;
  logic                   write_q, write_d;
  logic [1:0]             size_q, size_d;
  logic                   uns_q, uns_d;
  logic [BIT_WIDTH-1:0]   addr_q, addr_d;
  logic [BIT_WIDTH-1:0]   wdata_q, wdata_d;
  logic [BIT_WIDTH-1:0]   rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   misaligned;

  // Store data is lane-placed at accept time so DDT is a plain register during BUS.
  function automatic logic [BIT_WIDTH-1:0] store_lane(input logic [1:0] sz,
                                                      input logic [BIT_WIDTH-1:0] w);
    case (sz)
      2'b00:   store_lane = w;
      2'b01:   store_lane = {{(BIT_WIDTH-16){1'b0}}, w[15:0]};
      default: store_lane = {{(BIT_WIDTH-8){1'b0}}, w[7:0]};
    endcase
  endfunction

  function automatic logic [BIT_WIDTH-1:0] load_ext(input logic [1:0] sz, input logic uns,
                                                    input logic [BIT_WIDTH-1:0] d);
    case (sz)
      2'b00:   load_ext = d;
      2'b01:   load_ext = {{(BIT_WIDTH-16){d[15] & ~uns}}, d[15:0]};
      default: load_ext = {{(BIT_WIDTH-8){d[7] & ~uns}}, d[7:0]};
    endcase
  endfunction

  assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b00) && (req_addr[1:0] != 2'b00));

  always_comb begin
    state_d = state_q;
    mreq_d  = mreq_q;
    write_d = write_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = store_lane(req_size, req_wdata);
          rdata_d = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          if (misaligned) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d = BUS;
            mreq_d  = 1'b1;
          end
        end
      end
      BUS: begin
        // Ack takes priority over a timeout landing on the same edge.
        if (ACKD_n == 1'b0) begin
          state_d = DONE;
          mreq_d  = 1'b0;
          err_d   = 1'b0;
          rdata_d = write_q ? '0 : load_ext(size_q, uns_q, DDT);
        end else if (HAS_TIMEOUT && (cnt_q == CNT_LAST)) begin
          state_d = DONE;
          mreq_d  = 1'b0;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        mreq_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mreq_q  <= 1'b0;
      write_q <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mreq_q  <= mreq_d;
      write_q <= write_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready  = (state_q == IDLE) && !rst;
  assign resp_valid = (state_q == DONE);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign MREQ       = mreq_q;
  assign WRITE      = write_q;
  assign SIZE       = size_q;
  assign DAD        = addr_q;
  assign DDT        = (mreq_q && write_q) ? wdata_q : {BIT_WIDTH{1'bz}};

endmodule

// File: tb/tb_dmem_bus_master.sv
module tb_dmem_bus_master;

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem;
    int          dly;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] exp_ddt;
  } vec_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk, rst;
  logic        req_valid, req_write, req_unsigned, ACKD_n;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, MREQ, WRITE;
  logic [1:0]  SIZE;
  logic [31:0] resp_rdata, DAD;
  wire  [31:0] ddt;
  logic        mem_oe;
  logic [31:0] mem_drv;
  assign ddt = mem_oe ? mem_drv : 32'bz;

  logic        rv_t, rw_t, ru_t, ack_t;
  logic [1:0]  rs_t;
  logic [31:0] ra_t, rd_t;
  logic        rr_t, vv_t, ve_t, mreq_t, wr_t;
  logic [1:0]  sz_t;
  logic [31:0] rdat_t, dad_t;
  wire  [31:0] ddt_t;
  logic        oe_t;
  logic [31:0] drv_t;
  assign ddt_t = oe_t ? drv_t : 32'bz;

  dmem_bus_master dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .MREQ(MREQ), .WRITE(WRITE),
    .SIZE(SIZE), .DAD(DAD), .DDT(ddt), .ACKD_n(ACKD_n)
  );

  dmem_bus_master #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut_to (
    .clk(clk), .rst(rst), .req_valid(rv_t), .req_ready(rr_t),
    .req_write(rw_t), .req_size(rs_t), .req_unsigned(ru_t),
    .req_addr(ra_t), .req_wdata(rd_t), .resp_valid(vv_t),
    .resp_rdata(rdat_t), .resp_err(ve_t), .MREQ(mreq_t), .WRITE(wr_t),
    .SIZE(sz_t), .DAD(dad_t), .DDT(ddt_t), .ACKD_n(ack_t)
  );

  int   n_pass = 0;
  int   n_total = 0;
  exp_t sb_q[$];
  vec_t vecs[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic wr, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] mem,
                     input int dly, input logic [31:0] er, input logic ee, input logic [31:0] ed);
    vec_t v;
    v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wdata; v.mem = mem;
    v.dly = dly; v.exp_rdata = er; v.exp_err = ee; v.exp_ddt = ed;
    vecs.push_back(v);
  endtask

  // Scoreboard: every resp_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (sb_q.size() == 0) chk("unexpected_resp_valid", resp_valid, 1'b0);
      else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", resp_err, e.err);
      end
    end
  end

  task automatic run(input vec_t v);
    exp_t e;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_write = v.wr; req_size = v.sz; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    e.rdata = v.exp_rdata; e.err = v.exp_err;
    sb_q.push_back(e);
    @(negedge clk);
    // Scramble request inputs: they must be ignored once accepted.
    req_valid = 1'b0; req_addr = ~v.addr; req_wdata = ~v.wdata;
    req_size = ~v.sz; req_write = ~v.wr; req_unsigned = ~v.uns;
    if (v.exp_err) begin
      chk("misaligned_mreq", MREQ, 1'b0);
      chk("misaligned_resp_valid", resp_valid, 1'b1);
    end else begin
      for (int i = 0; i < v.dly; i++) begin
        chk("bus_mreq", MREQ, 1'b1);
        chk("bus_write", WRITE, v.wr);
        chk("bus_size", SIZE, v.sz);
        chk("bus_dad", DAD, v.addr);
        chk("bus_no_resp", resp_valid, 1'b0);
        if (v.wr) chk("bus_ddt", ddt, v.exp_ddt);
        if (i == v.dly - 1) begin
          ACKD_n = 1'b0;
          if (!v.wr) begin mem_drv = v.mem; mem_oe = 1'b1; end
        end
        @(negedge clk);
      end
      ACKD_n = 1'b1; mem_oe = 1'b0;
      chk("ack_mreq_drop", MREQ, 1'b0);
      chk("ack_resp_valid", resp_valid, 1'b1);
      chk("done_req_ready", req_ready, 1'b0);
      if (v.wr) begin
        mem_drv = 32'h5A5A_5A5A; mem_oe = 1'b1;
        #1;
        chk("ddt_released", ddt, 32'h5A5A_5A5A);
        mem_oe = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; ACKD_n = 1'b1; mem_oe = 1'b0; mem_drv = '0;
    rv_t = 1'b0; rw_t = 1'b0; rs_t = 2'b00; ru_t = 1'b0; ra_t = '0; rd_t = '0;
    ack_t = 1'b1; oe_t = 1'b0; drv_t = '0;

    //   wr    sz     uns   addr          wdata         mem           dly exp_rdata     err  exp_ddt
    add(1'b0, 2'b00, 1'b0, 32'h0800_0010, 32'h0,        32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 1'b0, 32'h0);
    add(1'b0, 2'b10, 1'b0, 32'h0800_0003, 32'h0,        32'h1234_5680, 1, 32'hFFFF_FF80, 1'b0, 32'h0);
    add(1'b0, 2'b10, 1'b1, 32'h0800_0003, 32'h0,        32'h1234_5680, 1, 32'h0000_0080, 1'b0, 32'h0);
    add(1'b1, 2'b10, 1'b0, 32'hF000_0000, 32'hAABB_CC41, 32'h0,        1, 32'h0,         1'b0, 32'h0000_0041);
    add(1'b1, 2'b01, 1'b0, 32'h0800_0102, 32'h1234_ABCD, 32'h0,        5, 32'h0,         1'b0, 32'h0000_ABCD);
    add(1'b0, 2'b01, 1'b0, 32'h0800_0001, 32'h0,        32'h0,        1, 32'h0,         1'b1, 32'h0);
    add(1'b0, 2'b00, 1'b0, 32'h0800_0002, 32'h0,        32'h0,        1, 32'h0,         1'b1, 32'h0);
    add(1'b0, 2'b01, 1'b0, 32'h0800_0002, 32'h0,        32'hFFFF_8001, 2, 32'hFFFF_8001, 1'b0, 32'h0);
    add(1'b0, 2'b01, 1'b1, 32'h0800_0002, 32'h0,        32'hFFFF_8001, 1, 32'h0000_8001, 1'b0, 32'h0);
    add(1'b1, 2'b00, 1'b0, 32'hFF00_0000, 32'h8000_0007, 32'h0,        2, 32'h0,         1'b0, 32'h8000_0007);
    add(1'b0, 2'b11, 1'b0, 32'h0800_0005, 32'h0,        32'hAAAA_AA7F, 1, 32'h0000_007F, 1'b0, 32'h0);
    add(1'b0, 2'b00, 1'b0, 32'h0800_0008, 32'h0,        32'h0123_4567, 3, 32'h0123_4567, 1'b0, 32'h0);
    add(1'b1, 2'b00, 1'b0, 32'h0800_0001, 32'h1111_1111, 32'h0,        1, 32'h0,         1'b1, 32'h0);

    repeat (2) @(negedge clk);
    chk("rst_mreq", MREQ, 1'b0);
    chk("rst_write", WRITE, 1'b0);
    chk("rst_size", SIZE, 2'b00);
    chk("rst_dad", DAD, 32'h0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", resp_err, 1'b0);
    chk("rst_req_ready", req_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", req_ready, 1'b1);

    for (int i = 0; i < vecs.size(); i++) run(vecs[i]);

    // Acknowledge while idle is ignored.
    ACKD_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ack_mreq", MREQ, 1'b0);
      chk("idle_ack_resp", resp_valid, 1'b0);
    end
    ACKD_n = 1'b1;

    // Reset in the middle of a bus cycle abandons it without a response.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b00; req_addr = 32'h0800_0040;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstbus_mreq0", MREQ, 1'b1);
    @(negedge clk);
    chk("rstbus_mreq1", MREQ, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstbus_mreq_drop", MREQ, 1'b0);
    chk("rstbus_no_resp", resp_valid, 1'b0);
    chk("rstbus_dad", DAD, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstbus_ready", req_ready, 1'b1);
    repeat (3) @(negedge clk);

    // Timeout instance: ACKD_n stuck high.
    rv_t = 1'b1; rw_t = 1'b0; rs_t = 2'b00; ra_t = 32'h0800_0020;
    @(negedge clk);
    rv_t = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_mreq_held", mreq_t, 1'b1);
      chk("to_no_resp", vv_t, 1'b0);
      @(negedge clk);
    end
    chk("to_mreq_drop", mreq_t, 1'b0);
    chk("to_resp_valid", vv_t, 1'b1);
    chk("to_resp_err", ve_t, 1'b1);
    chk("to_resp_rdata", rdat_t, 32'h0);
    @(negedge clk);
    chk("to_resp_pulse", vv_t, 1'b0);

    // Ack on the same edge as the timeout: ack wins.
    rv_t = 1'b1; ra_t = 32'h0800_0024;
    @(negedge clk);
    rv_t = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("tie_mreq_held", mreq_t, 1'b1);
      if (i == 3) begin ack_t = 1'b0; drv_t = 32'hCAFE_F00D; oe_t = 1'b1; end
      @(negedge clk);
    end
    ack_t = 1'b1; oe_t = 1'b0;
    chk("tie_resp_valid", vv_t, 1'b1);
    chk("tie_resp_err", ve_t, 1'b0);
    chk("tie_resp_rdata", rdat_t, 32'hCAFE_F00D);

    @(negedge clk);
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
